// File: rtl/gray_defs_pkg.sv
// rtl/gray_defs_pkg.sv - shared definitions for the Gray-code decoder/monitor
//
// Purpose : FSM state encoding, default word width and wrap-counter width
//           used by gray_decoder and gray2bin.
// Ports   : none (package).
package gray_defs;

  localparam int DEFAULT_WIDTH = 3;
  localparam int WRAP_CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_e;

endpackage

// File: rtl/gray2bin.sv
// rtl/gray2bin.sv - combinational Gray-to-binary converter
//
// Purpose : b[W-1] = g[W-1], b[i] = b[i+1] ^ g[i]. Reusable as a reference
//           model by the Gray counter bench.
// Ports   : i_gray   [WIDTH-1:0]  Gray-coded word
//           o_binary [WIDTH-1:0]  decoded binary word
module gray2bin
  import gray_defs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_binary
);

  // Running XOR from the MSB down; each binary bit is the parity of all
  // Gray bits at or above it.
  logic w_acc;

  always_comb begin
    o_binary = '0;
    w_acc    = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      w_acc       = w_acc ^ i_gray[i];
      o_binary[i] = w_acc;
    end
  end

endmodule

// File: rtl/gray_decoder.sv
// rtl/gray_decoder.sv - Gray stream decoder with step checking and wrap counting
//
// Purpose : samples a Gray-coded stream on valid cycles, decodes it, checks
//           that each sample is a hold or a +1 step, flags wraps and latches
//           a sticky error on any other transition.
// Ports   : i_clk                         rising-edge clock
//           i_rst_n                       asynchronous active-low reset
//           i_valid                       sample qualifier
//           i_gray       [WIDTH-1:0]      Gray-coded input word
//           i_clear                       leaves ERROR, returns to IDLE
//           o_binary     [WIDTH-1:0]      decoded value of last accepted sample
//           o_locked                      high while tracking
//           o_wrap                        one-cycle pulse on accepted max->0 step
//           o_error                       sticky illegal-transition flag
//           o_wrap_count [WRAP_CNT_W-1:0] wraps since lock, saturating
module gray_decoder
  import gray_defs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic [WIDTH-1:0]      i_gray,
  input  logic                  i_clear,
  output logic [WIDTH-1:0]      o_binary,
  output logic                  o_locked,
  output logic                  o_wrap,
  output logic                  o_error,
  output logic [WRAP_CNT_W-1:0] o_wrap_count
);

  state_e                r_state;
  logic [WIDTH-1:0]      r_binary;
  logic                  r_locked;
  logic                  r_wrap;
  logic                  r_error;
  logic [WRAP_CNT_W-1:0] r_wrap_cnt;

  logic [WIDTH-1:0]      w_dec;
  logic [WIDTH-1:0]      w_inc;
  logic                  w_at_max;

  gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
    .i_gray   (i_gray),
    .o_binary (w_dec)
  );

  // WIDTH-bit add wraps max->0 naturally, matching the modulo step rule.
  assign w_inc    = r_binary + {{(WIDTH-1){1'b0}}, 1'b1};
  assign w_at_max = &r_binary;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_binary   <= '0;
      r_locked   <= 1'b0;
      r_wrap     <= 1'b0;
      r_error    <= 1'b0;
      r_wrap_cnt <= '0;
    end else begin
      r_wrap <= 1'b0;
      case (r_state)
        IDLE: begin
          // First sample after reset or clear is trusted without checking.
          if (i_valid) begin
            r_binary   <= w_dec;
            r_wrap_cnt <= '0;
            r_locked   <= 1'b1;
            r_state    <= TRACK;
          end
        end
        TRACK: begin
          if (i_valid && (w_dec != r_binary)) begin
            if (w_dec == w_inc) begin
              r_binary <= w_dec;
              if (w_at_max) begin
                r_wrap <= 1'b1;
                if (!(&r_wrap_cnt)) begin
                  r_wrap_cnt <= r_wrap_cnt + 1'b1;
                end
              end
            end else begin
              // Binary keeps the last good value for post-mortem inspection.
              r_error  <= 1'b1;
              r_locked <= 1'b0;
              r_state  <= ERROR;
            end
          end
        end
        ERROR: begin
          // Clear takes priority over any sample presented in the same cycle.
          if (i_clear) begin
            r_error    <= 1'b0;
            r_wrap_cnt <= '0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_locked <= 1'b0;
          r_error  <= 1'b0;
        end
      endcase
    end
  end

  assign o_binary     = r_binary;
  assign o_locked     = r_locked;
  assign o_wrap       = r_wrap;
  assign o_error      = r_error;
  assign o_wrap_count = r_wrap_cnt;

endmodule

// File: tb/tb_gray_decoder.sv
// tb/tb_gray_decoder.sv - self-checking bench for gray_decoder (WIDTH=3)
module tb_gray_decoder;

  localparam int W   = 3;
  localparam int MOD = 1 << W;

  logic         clk;
  logic         rst_n;
  logic         valid;
  logic [W-1:0] gray;
  logic         clear;
  logic [W-1:0] binary;
  logic         locked;
  logic         wrap;
  logic         error;
  logic [7:0]   wrap_count;

  gray_decoder #(.WIDTH(W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (valid),
    .i_gray       (gray),
    .i_clear      (clear),
    .o_binary     (binary),
    .o_locked     (locked),
    .o_wrap       (wrap),
    .o_error      (error),
    .o_wrap_count (wrap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain integers describing the observable behaviour.
  int m_bin, m_cnt;
  bit m_locked, m_err, m_wrap;

  function automatic int to_gray(int n);
    return (n ^ (n >> 1)) % MOD;
  endfunction

  // Decode by searching the encode table rather than by bitwise XOR chains.
  function automatic int from_gray(int g);
    for (int n = 0; n < MOD; n++) if (to_gray(n) == g) return n;
    return -1;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bin = 0; m_cnt = 0; m_locked = 0; m_err = 0; m_wrap = 0;
  endtask

  task automatic model_step(input bit v, input int g, input bit c);
    int d;
    m_wrap = 0;
    if (m_err) begin
      if (c) begin m_err = 0; m_cnt = 0; end
    end else if (!m_locked) begin
      if (v) begin m_bin = from_gray(g); m_cnt = 0; m_locked = 1; end
    end else if (v) begin
      d = from_gray(g);
      if (d == (m_bin + 1) % MOD) begin
        if (m_bin == MOD - 1) begin
          m_wrap = 1;
          if (m_cnt < 255) m_cnt++;
        end
        m_bin = d;
      end else if (d != m_bin) begin
        m_err = 1; m_locked = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".binary"}, int'(binary), m_bin);
    check({tag, ".locked"}, int'(locked), int'(m_locked));
    check({tag, ".wrap"},   int'(wrap),   int'(m_wrap));
    check({tag, ".error"},  int'(error),  int'(m_err));
    check({tag, ".wcount"}, int'(wrap_count), m_cnt);
  endtask

  // Called 1 time unit after a rising edge; drives, clocks, then checks.
  task automatic cycle(input string tag, input bit v, input int g, input bit c);
    valid = v; gray = W'(g); clear = c;
    @(posedge clk);
    model_step(v, g, c);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    valid = 0; clear = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all(tag);
    @(posedge clk); #1;
    check_all(tag);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check_all(tag);
  endtask

  initial begin
    int r, tgt;
    rst_n = 1'b0; valid = 0; gray = '0; clear = 0;
    model_reset();
    @(posedge clk); #1;
    check_all("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("post_reset");

    // Full cycle 0..7 then 0.
    for (int n = 0; n <= MOD; n++) cycle("full", 1, to_gray(n % MOD), 0);
    check("full.final_wcount", int'(wrap_count), 1);

    // Hold then valid gating.
    cycle("hold", 1, 3'b001, 0);
    for (int i = 0; i < 4; i++) cycle("hold", 1, 3'b011, 0);
    for (int i = 0; i < 3; i++) cycle("gate", 0, 3'b110, 0);
    check("gate.binary", int'(binary), 2);

    // Illegal step.
    do_reset("rst_a");
    cycle("illegal", 1, 3'b001, 0);
    cycle("illegal", 1, 3'b010, 0);
    check("illegal.error", int'(error), 1);
    check("illegal.binary", int'(binary), 1);
    for (int i = 0; i < 3; i++) cycle("ignored", 1, $urandom_range(0, MOD - 1), 0);

    // Recovery: Clear wins over a same-cycle sample.
    cycle("recover", 1, 3'b110, 1);
    cycle("recover", 1, 3'b110, 0);
    check("recover.binary", int'(binary), 4);

    // Reach Binary=5 with two wraps, then reset asynchronously between edges.
    for (int n = 5; n <= 21; n++) cycle("walk", 1, to_gray(n % MOD), 0);
    check("walk.wcount", int'(wrap_count), 2);
    valid = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    check("async_rst.binary", int'(binary), 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    cycle("relock", 1, 3'b101, 0);
    check("relock.binary", int'(binary), 6);

    // Randomized traffic: mostly holds and steps, occasional illegal jumps.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 15);
      if (r < 5)       tgt = m_bin;
      else if (r < 14) tgt = (m_bin + 1) % MOD;
      else             tgt = $urandom_range(0, MOD - 1);
      cycle("rand", ($urandom_range(0, 3) != 0), to_gray(tgt),
            ($urandom_range(0, 7) == 0));
    end

    // Saturation over 300 full cycles.
    do_reset("rst_b");
    for (int n = 0; n <= 300 * MOD; n++) cycle("sat", 1, to_gray(n % MOD), 0);
    check("sat.wcount", int'(wrap_count), 255);
    check("sat.wrap", int'(wrap), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
